// File: rtl/tile_line_renderer.sv
// Tile-map line renderer: fetches glyph index, bitmap and palette for each pixel
// of one scanline and streams RGB332 colours into the inactive line buffer bank.
module tile_line_renderer #(
  parameter int LINE_PIXELS   = 512,
  parameter int LB_ADDR_WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [8:0]               line_y,
  input  logic                     bank,
  output logic                     busy,
  output logic                     done,
  output logic                     overrun,
  output logic [11:0]              char_addr,
  input  logic [7:0]               char_data,
  output logic [11:0]              gfx_addr,
  input  logic [7:0]               gfx_data,
  output logic [9:0]               pal_addr,
  input  logic [7:0]               pal_data,
  output logic                     lb_we,
  output logic [LB_ADDR_WIDTH-1:0] lb_addr,
  output logic [7:0]               lb_data
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | one glyph-map fetch per cycle, x = 0..LINE_PIXELS-1
  // DRAIN | 4 cycles while the fetch pipeline empties
  // DONE  | done pulse, back to IDLE
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int         XW     = LB_ADDR_WIDTH - 1;
  localparam logic [8:0] X_LAST = 9'(LINE_PIXELS - 1);

  state_t     state;
  logic [8:0] x;
  logic [8:0] y_q;
  logic       bank_q;
  logic [1:0] drain_cnt;
  logic [8:0] x_c0, x_d1, x_d2, x_d3;
  logic       v0, v1, v2, v3;
  logic [7:0] glyph_d2;
  logic [1:0] pix;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      x         <= '0;
      y_q       <= '0;
      bank_q    <= 1'b0;
      drain_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
      char_addr <= '0;
      x_c0      <= '0;
      v0        <= 1'b0;
    end else begin
      done <= 1'b0;
      v0   <= 1'b0;
      if (start && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            y_q    <= line_y;
            bank_q <= bank;
            x      <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          char_addr <= {y_q[8:3], x[8:3]};
          x_c0      <= x;
          v0        <= 1'b1;
          if (x == X_LAST) begin
            drain_cnt <= 2'd3;
            state     <= DRAIN;
          end else begin
            x <= x + 9'd1;
          end
        end
        DRAIN: begin
          if (drain_cnt == 2'd0) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            drain_cnt <= drain_cnt - 2'd1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // x and glyph travel with the memory latency so each palette lookup
  // belongs to the same pixel as its bitmap fetch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_d1     <= '0;
      x_d2     <= '0;
      x_d3     <= '0;
      v1       <= 1'b0;
      v2       <= 1'b0;
      v3       <= 1'b0;
      glyph_d2 <= '0;
      lb_we    <= 1'b0;
      lb_addr  <= '0;
      lb_data  <= '0;
    end else begin
      x_d1     <= x_c0;
      v1       <= v0;
      x_d2     <= x_d1;
      v2       <= v1;
      glyph_d2 <= char_data;
      x_d3     <= x_d2;
      v3       <= v2;
      lb_we    <= v3;
      lb_addr  <= {bank_q, XW'(x_d3)};
      lb_data  <= pal_data;
    end
  end

  assign gfx_addr = {char_data, y_q[2:0], x_d1[2]};

  always_comb begin
    pix = gfx_data[7:6];
    case (x_d2[1:0])
      2'd0: pix = gfx_data[7:6];
      2'd1: pix = gfx_data[5:4];
      2'd2: pix = gfx_data[3:2];
      2'd3: pix = gfx_data[1:0];
      default: pix = gfx_data[7:6];
    endcase
  end

  assign pal_addr = {glyph_d2, pix};

endmodule

// File: tb/tb_tile_line_renderer.sv
// Directed bench for tile_line_renderer: BRAM models with 1-cycle reads and a
// line recorder that captures every line buffer write.
module tb_tile_line_renderer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [8:0]  line_y;
  logic        bank;
  logic        busy, done, overrun;
  logic [11:0] char_addr;
  logic [7:0]  char_data;
  logic [11:0] gfx_addr;
  logic [7:0]  gfx_data;
  logic [9:0]  pal_addr;
  logic [7:0]  pal_data;
  logic        lb_we;
  logic [9:0]  lb_addr;
  logic [7:0]  lb_data;

  tile_line_renderer #(.LINE_PIXELS(512), .LB_ADDR_WIDTH(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .line_y(line_y), .bank(bank),
    .busy(busy), .done(done), .overrun(overrun),
    .char_addr(char_addr), .char_data(char_data),
    .gfx_addr(gfx_addr), .gfx_data(gfx_data),
    .pal_addr(pal_addr), .pal_data(pal_data),
    .lb_we(lb_we), .lb_addr(lb_addr), .lb_data(lb_data)
  );

  always #5 clk = ~clk;

  logic [7:0] char_mem [4096];
  logic [7:0] gfx_mem  [4096];
  logic [7:0] pal_mem  [1024];

  always @(posedge clk) begin
    char_data <= char_mem[char_addr];
    gfx_data  <= gfx_mem[gfx_addr];
    pal_data  <= pal_mem[pal_addr];
  end

  int vectors = 0;
  int miscompares = 0;

  int wr_cnt, first_we, last_we, done_cyc, done_cnt, addr_err, timed_out;
  int rst_we, rst_busy, rst_seen;
  logic [7:0]  got   [512];
  logic [11:0] g_cap [16];
  logic [9:0]  p_cap [16];

  // Cycle 0 is the cycle right after the edge that samples start.
  task automatic run_line(input logic b, input logic [8:0] y,
                          input int restart_cyc, input int rst_at_write);
    bit rst_pending = 0;
    wr_cnt = 0; first_we = -1; last_we = -1; done_cyc = -1; done_cnt = 0;
    addr_err = 0; timed_out = 1; rst_seen = 0; rst_we = 0; rst_busy = 0;
    @(negedge clk);
    line_y = y; bank = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; line_y = ~y; bank = ~b;
    for (int c = 1; c < 700; c++) begin
      @(negedge clk);
      start = (c == restart_cyc);
      if (rst_pending) begin
        rst_seen = 1; rst_we = lb_we; rst_busy = busy;
        if (done) done_cnt++;
        rst_n = 1'b1; timed_out = 0;
        break;
      end
      if (c < 16) begin g_cap[c] = gfx_addr; p_cap[c] = pal_addr; end
      if (lb_we) begin
        if (first_we < 0) first_we = c;
        last_we = c;
        if (lb_addr !== {b, wr_cnt[8:0]}) addr_err++;
        if (wr_cnt < 512) got[wr_cnt] = lb_data;
        wr_cnt++;
      end
      if (done) begin done_cnt++; done_cyc = c; timed_out = 0; break; end
      if (rst_at_write > 0 && wr_cnt == rst_at_write) begin
        rst_n = 1'b0; rst_pending = 1;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; line_y = '0; bank = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, done, overrun, lb_we} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_flags got busy/done/ovr/we=%b want 0000", {busy, done, overrun, lb_we});
    end
    vectors++;
    if (lb_addr !== 10'd0 || lb_data !== 8'd0 || char_addr !== 12'd0) begin
      miscompares++;
      $display("FAIL reset_regs got addr=%h data=%h char=%h want 0", lb_addr, lb_data, char_addr);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_common(input string nm, input int exp_writes);
    vectors++;
    if (timed_out != 0) begin
      miscompares++; $display("FAIL %s_timeout got no done within budget", nm);
    end
    vectors++;
    if (wr_cnt !== exp_writes) begin
      miscompares++; $display("FAIL %s_writes got %0d want %0d", nm, wr_cnt, exp_writes);
    end
    vectors++;
    if (first_we !== 5) begin
      miscompares++; $display("FAIL %s_first_we got cycle %0d want 5", nm, first_we);
    end
    vectors++;
    if (addr_err !== 0) begin
      miscompares++; $display("FAIL %s_addr got %0d bad addresses want 0", nm, addr_err);
    end
    vectors++;
    if (done_cyc !== 516 || last_we !== 516 || done_cnt !== 1) begin
      miscompares++;
      $display("FAIL %s_done got done=%0d last_we=%0d pulses=%0d want 516/516/1", nm, done_cyc, last_we, done_cnt);
    end
  endtask

  task automatic check_pattern(input string nm, input int kind);
    int bad = 0; int first_bad = -1;
    logic [7:0] e;
    logic [7:0] p0 [4];
    p0[0] = 8'h00; p0[1] = 8'h55; p0[2] = 8'hAA; p0[3] = 8'hFF;
    for (int i = 0; i < 512; i++) begin
      if (kind == 0) e = p0[i % 4];
      else e = (((i / 8) % 2) == 1 ? 8'h80 : 8'h00) + 8'((i % 4) + 1);
      if (got[i] !== e) begin bad++; if (first_bad < 0) first_bad = i; end
    end
    vectors++;
    if (bad != 0) begin
      miscompares++; $display("FAIL %s_pixels got %0d wrong pixels (first at x=%0d) want 0", nm, bad, first_bad);
    end
  endtask

  task automatic test_basic_line;
    run_line(1'b0, 9'd0, -1, 0);
    check_common("basic", 512);
    check_pattern("basic", 0);
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || lb_we !== 1'b0) begin
      miscompares++; $display("FAIL basic_idle got busy=%b we=%b want 0 0", busy, lb_we);
    end
  endtask

  task automatic test_bank_row;
    logic [7:0] e8 [8];
    logic [1:0] px [8];
    int bad = 0;
    e8 = '{8'h40, 8'h30, 8'h20, 8'h10, 8'h10, 8'h20, 8'h30, 8'h40};
    px = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
    run_line(1'b1, 9'd13, -1, 0);
    check_common("bank1", 512);
    for (int k = 0; k < 8; k++) begin
      logic [2:0] kk;
      kk = 3'(k);
      if (got[k] !== e8[k]) bad++;
      if (g_cap[k + 2] !== {8'h07, 3'd5, kk[2]}) bad++;
      if (p_cap[k + 3] !== {8'h07, px[k]}) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++; $display("FAIL bank1_glyph7 got %0d wrong addr/pixel values want 0", bad);
    end
    vectors++;
    if (got[8] !== 8'h00 || got[11] !== 8'hFF) begin
      miscompares++; $display("FAIL bank1_glyph0 got %h %h want 00 ff", got[8], got[11]);
    end
  endtask

  task automatic test_alt_glyphs;
    run_line(1'b0, 9'd24, -1, 0);
    check_common("alt", 512);
    check_pattern("alt", 1);
    vectors++;
    if (got[63] !== 8'h84 || got[64] !== 8'h01) begin
      miscompares++; $display("FAIL alt_boundary got x63=%h x64=%h want 84 01", got[63], got[64]);
    end
  endtask

  task automatic test_overrun;
    vectors++;
    if (overrun !== 1'b0) begin
      miscompares++; $display("FAIL ovr_pre got %b want 0", overrun);
    end
    run_line(1'b0, 9'd24, 100, 0);
    check_common("ovr", 512);
    check_pattern("ovr", 1);
    repeat (3) @(negedge clk);
    vectors++;
    if (overrun !== 1'b1 || busy !== 1'b0) begin
      miscompares++; $display("FAIL ovr_sticky got ovr=%b busy=%b want 1 0", overrun, busy);
    end
  endtask

  task automatic test_mid_reset;
    run_line(1'b1, 9'd24, -1, 200);
    vectors++;
    if (rst_seen !== 1 || rst_we !== 0 || rst_busy !== 0 || done_cnt !== 0) begin
      miscompares++;
      $display("FAIL midrst got seen=%0d we=%0d busy=%0d done=%0d want 1 0 0 0", rst_seen, rst_we, rst_busy, done_cnt);
    end
    vectors++;
    if (wr_cnt !== 200 || overrun !== 1'b0) begin
      miscompares++; $display("FAIL midrst_state got writes=%0d ovr=%b want 200 0", wr_cnt, overrun);
    end
    run_line(1'b0, 9'd24, -1, 0);
    check_common("after_rst", 512);
    check_pattern("after_rst", 1);
  endtask

  task automatic test_back_to_back;
    run_line(1'b0, 9'd0, -1, 0);
    check_common("b2b_first", 512);
    run_line(1'b1, 9'd13, -1, 0);
    check_common("b2b_second", 512);
    vectors++;
    if (got[0] !== 8'h40 || got[8] !== 8'h00 || overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_data got %h %h ovr=%b want 40 00 0", got[0], got[8], overrun);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin char_mem[i] = 8'h00; gfx_mem[i] = 8'h00; end
    for (int i = 0; i < 1024; i++) pal_mem[i] = 8'h00;
    for (int i = 0; i < 16; i++) gfx_mem[i] = 8'h1B;
    pal_mem[0] = 8'h00; pal_mem[1] = 8'h55; pal_mem[2] = 8'hAA; pal_mem[3] = 8'hFF;
    char_mem[64] = 8'h07;
    gfx_mem[122] = 8'hE4; gfx_mem[123] = 8'h1B;
    pal_mem[28] = 8'h10; pal_mem[29] = 8'h20; pal_mem[30] = 8'h30; pal_mem[31] = 8'h40;
    for (int c = 0; c < 64; c++) char_mem[192 + c] = (c % 2 == 1) ? 8'h02 : 8'h01;
    gfx_mem[16] = 8'h1B; gfx_mem[17] = 8'h1B; gfx_mem[32] = 8'h1B; gfx_mem[33] = 8'h1B;
    for (int k = 0; k < 4; k++) begin
      pal_mem[4 + k] = 8'(8'h01 + k);
      pal_mem[8 + k] = 8'(8'h81 + k);
    end

    test_reset();
    test_basic_line();
    test_bank_row();
    test_alt_glyphs();
    test_overrun();
    test_mid_reset();
    test_back_to_back();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
